// File: rtl/game_tick_if.sv
// Handshake-free control/strobe bundle for game_tick_sched.
// master drives run/config/fright inputs, slave produces strobes.
interface game_tick_if;
  logic        run;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_period;
  logic        fright_start;
  logic [11:0] fright_len;
  logic        tick_base;
  logic [3:0]  tick;
  logic        fright_active;
  logic        fright_warn;
  logic        fright_done;

  modport master (
    output run, cfg_we, cfg_sel, cfg_period,
    output fright_start, fright_len,
    input  tick_base, tick,
    input  fright_active, fright_warn, fright_done
  );

  modport slave (
    input  run, cfg_we, cfg_sel, cfg_period,
    input  fright_start, fright_len,
    output tick_base, tick,
    output fright_active, fright_warn, fright_done
  );
endinterface

// File: rtl/game_tick_sched.sv
// Game timing scheduler: base prescaler, four tick channels
// and the power-pellet frightened timer.
module game_tick_sched #(
  parameter int          PRESCALE   = 500_000,
  parameter logic [7:0]  DEF_PERIOD = 8'd10,
  parameter logic [11:0] WARN_TICKS = 12'd200
) (
  input logic       clk,
  input logic       rst_n,
  game_tick_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_ACTIVE,
    F_WARN
  } fstate_e;

  logic [PW-1:0]     pre_q, pre_d;
  logic              strobe;
  logic              base_q;
  logic [3:0][7:0]   per_q, per_d;
  logic [3:0][7:0]   cnt_q, cnt_d;
  logic [3:0]        tick_q, tick_d;
  fstate_e           st_q, st_d;
  logic [11:0]       fc_q, fc_d;
  logic              done_q, done_d;
  logic              act_q, warn_q;

  always_comb begin
    strobe = bus.run && (pre_q == PRE_MAX);
    pre_d  = pre_q;
    if (bus.run) begin
      pre_d = strobe ? '0 : pre_q + PW'(1);
    end
  end

  // A config write restarts the channel phase and masks its tick.
  always_comb begin
    per_d  = per_q;
    cnt_d  = cnt_q;
    tick_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cfg_we && bus.cfg_sel == 2'(i)) begin
        per_d[i] = bus.cfg_period;
        cnt_d[i] = bus.cfg_period - 8'd1;
      end else if (strobe && per_q[i] != 8'd0) begin
        if (cnt_q[i] == 8'd0) begin
          cnt_d[i]  = per_q[i] - 8'd1;
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    fc_d   = fc_q;
    done_d = 1'b0;
    if (bus.fright_start) begin
      fc_d = bus.fright_len;
      unique case (1'b1)
        (bus.fright_len == 12'd0): st_d = F_IDLE;
        (bus.fright_len != 12'd0 &&
         bus.fright_len <= WARN_TICKS): st_d = F_WARN;
        (bus.fright_len > WARN_TICKS): st_d = F_ACTIVE;
        default: st_d = F_IDLE;
      endcase
    end else if (strobe) begin
      unique case (st_q)
        F_ACTIVE, F_WARN: begin
          fc_d = fc_q - 12'd1;
          if (fc_d == 12'd0) begin
            st_d   = F_IDLE;
            done_d = 1'b1;
          end else if (fc_d <= WARN_TICKS) begin
            st_d = F_WARN;
          end
        end
        default: st_d = st_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      base_q <= 1'b0;
      per_q  <= {4{DEF_PERIOD}};
      cnt_q  <= {4{DEF_PERIOD - 8'd1}};
      tick_q <= '0;
      st_q   <= F_IDLE;
      fc_q   <= '0;
      done_q <= 1'b0;
      act_q  <= 1'b0;
      warn_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      base_q <= strobe;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      st_q   <= st_d;
      fc_q   <= fc_d;
      done_q <= done_d;
      act_q  <= (st_d != F_IDLE);
      warn_q <= (st_d == F_WARN);
    end
  end

  assign bus.tick_base     = base_q;
  assign bus.tick          = tick_q;
  assign bus.fright_active = act_q;
  assign bus.fright_warn   = warn_q;
  assign bus.fright_done   = done_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Randomized self-checking bench for game_tick_sched
// against a strobe-counting reference model.
module tb_game_tick_sched;

  localparam int P = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n;
  game_tick_if bus();

  game_tick_sched #(
    .PRESCALE(P),
    .WARN_TICKS(12'd3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int m_runs;
  int m_per [4];
  int m_since [4];
  int m_rem;
  logic [7:0] e;

  function automatic logic [7:0] obs();
    return {bus.tick_base, bus.tick, bus.fright_active,
            bus.fright_warn, bus.fright_done};
  endfunction

  task automatic m_reset();
    m_runs = 0;
    for (int i = 0; i < 4; i++) begin
      m_per[i] = 10;
      m_since[i] = 0;
    end
    m_rem = 0;
    e = '0;
  endtask

  // Model: strobe every P-th running cycle; channel i ticks
  // on every per[i]-th strobe since its last phase restart.
  task automatic step();
    logic s;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      s = bus.run && ((m_runs + 1) % P == 0);
      if (bus.run) m_runs++;
      e = '0;
      e[7] = s;
      for (int i = 0; i < 4; i++) begin
        if (bus.cfg_we && int'(bus.cfg_sel) == i) begin
          m_per[i] = int'(bus.cfg_period);
          m_since[i] = 0;
        end else if (s && m_per[i] != 0) begin
          m_since[i]++;
          if (m_since[i] % m_per[i] == 0) e[3+i] = 1'b1;
        end
      end
      if (bus.fright_start) begin
        m_rem = int'(bus.fright_len);
      end else if (s && m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) e[0] = 1'b1;
      end
      e[2] = (m_rem > 0);
      e[1] = (m_rem > 0) && (m_rem <= W);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.run = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_sel = 2'd0;
    bus.cfg_period = 8'd0;
    bus.fright_start = 1'b0;
    bus.fright_len = 12'd0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs() !== 8'h00)
        $display("FAIL reset c=%0d got=%b exp=%b", c, obs(), 8'h00);
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default();
    int nb = 0;
    int nt = 0;
    bus.run = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      nb += int'(bus.tick_base);
      nt += int'(bus.tick[3]);
      checks++;
      if (obs() !== e)
        $display("FAIL default c=%0d got=%b exp=%b", c, obs(), e);
      else passed++;
    end
    checks++;
    if (nb !== 25) $display("FAIL base_count got=%0d exp=25", nb);
    else passed++;
    checks++;
    if (nt !== 2) $display("FAIL tick3_count got=%0d exp=2", nt);
    else passed++;
  endtask

  task automatic test_config();
    int n0 = 0;
    logic [7:0] pv [3];
    pv[0] = 8'd1;
    pv[1] = 8'd3;
    pv[2] = 8'd0;
    bus.cfg_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.cfg_sel = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
      bus.cfg_period = pv[k];
      step();
      checks++;
      if (obs() !== e)
        $display("FAIL cfg_write k=%0d got=%b exp=%b", k, obs(), e);
      else passed++;
    end
    bus.cfg_we = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step();
      n0 += int'(bus.tick[0]);
      checks++;
      if (obs() !== e)
        $display("FAIL config c=%0d got=%b exp=%b", c, obs(), e);
      else passed++;
    end
    checks++;
    if (n0 !== 0) $display("FAIL ch0_disabled got=%0d exp=0", n0);
    else passed++;
  endtask

  task automatic test_pause();
    int nb = 0;
    for (int c = 0; c < 6; c++) step();
    bus.run = 1'b0;
    for (int c = 0; c < 37; c++) begin
      bus.cfg_we = (c == 10);
      bus.cfg_sel = 2'd3;
      bus.cfg_period = 8'd2;
      step();
      nb += int'(bus.tick_base);
      checks++;
      if (obs() !== e)
        $display("FAIL pause c=%0d got=%b exp=%b", c, obs(), e);
      else passed++;
    end
    bus.cfg_we = 1'b0;
    checks++;
    if (nb !== 0) $display("FAIL pause_strobes got=%0d exp=0", nb);
    else passed++;
    bus.run = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      checks++;
      if (obs() !== e)
        $display("FAIL resume c=%0d got=%b exp=%b", c, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_fright();
    int nd = 0;
    int g = 0;
    bus.fright_start = 1'b1;
    bus.fright_len = 12'd6;
    step();
    bus.fright_start = 1'b0;
    while (m_rem != 0 && g < 200) begin
      step();
      g++;
      nd += int'(bus.fright_done);
      checks++;
      if (obs() !== e)
        $display("FAIL fright c=%0d got=%b exp=%b", g, obs(), e);
      else passed++;
    end
    for (int c = 0; c < 8; c++) begin
      step();
      nd += int'(bus.fright_done);
    end
    checks++;
    if (nd !== 1 || g >= 200)
      $display("FAIL fright_done_count got=%0d exp=1", nd);
    else passed++;
  endtask

  task automatic test_retrigger();
    int nd = 0;
    int ns = 0;
    int g = 0;
    bus.fright_start = 1'b1;
    bus.fright_len = 12'd6;
    step();
    bus.fright_start = 1'b0;
    while (m_rem != 2 && g < 200) begin
      step();
      g++;
      nd += int'(bus.fright_done);
    end
    bus.fright_start = 1'b1;
    bus.fright_len = 12'd5;
    step();
    bus.fright_start = 1'b0;
    while (m_rem != 0 && g < 200) begin
      step();
      g++;
      ns += int'(bus.tick_base);
      nd += int'(bus.fright_done);
      checks++;
      if (obs() !== e)
        $display("FAIL retrig c=%0d got=%b exp=%b", g, obs(), e);
      else passed++;
    end
    checks++;
    if (ns !== 5 || nd !== 1 || g >= 200)
      $display("FAIL retrig_len strobes=%0d dones=%0d exp=5/1", ns, nd);
    else passed++;
    bus.fright_start = 1'b1;
    bus.fright_len = 12'd4;
    step();
    bus.fright_start = 1'b0;
    g = 0;
    while (!(m_rem == 1 && (m_runs + 1) % P == 0) && g < 200) begin
      step();
      g++;
    end
    bus.fright_start = 1'b1;
    bus.fright_len = 12'd5;
    step();
    bus.fright_start = 1'b0;
    checks++;
    if (obs() !== e || bus.fright_done !== 1'b0 || g >= 200)
      $display("FAIL start_at_expiry got=%b exp=%b", obs(), e);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      bus.run = ($urandom % 8) != 0;
      bus.cfg_we = ($urandom % 12) == 0;
      bus.cfg_sel = 2'($urandom % 4);
      bus.cfg_period = 8'($urandom % 6);
      bus.fright_start = ($urandom % 50) == 0;
      bus.fright_len = 12'($urandom % 12);
      step();
      checks++;
      if (obs() !== e)
        $display("FAIL random c=%0d got=%b exp=%b", c, obs(), e);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int n0 = 0;
    bus.run = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_sel = 2'd0;
    bus.cfg_period = 8'd2;
    step();
    bus.cfg_we = 1'b0;
    bus.fright_start = 1'b1;
    bus.fright_len = 12'd20;
    step();
    bus.fright_start = 1'b0;
    for (int c = 0; c < 15; c++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 8'h00)
      $display("FAIL async_reset got=%b exp=%b", obs(), 8'h00);
    else passed++;
    m_reset();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 90; c++) begin
      step();
      n0 += int'(bus.tick[0]);
      checks++;
      if (obs() !== e)
        $display("FAIL post_reset c=%0d got=%b exp=%b", c, obs(), e);
      else passed++;
    end
    checks++;
    if (n0 !== 2) $display("FAIL period_restored got=%0d exp=2", n0);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    m_reset();
    #2 rst_n = 1'b0;
    test_reset();
    test_default();
    test_config();
    test_pause();
    test_fright();
    test_retrigger();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
